// File: rtl/popcount_seq.sv
// Sequential population counter: counts CHUNK bits of the loaded word per cycle.
// Optional macro POPCOUNT_ZERO_SKIP_EN ends counting early once the remaining bits are all zero.
module popcount_seq #(
  parameter int BITS  = 64,
  parameter int CHUNK = 8
) (
  input  logic                     clk,
  input  logic                     CPU_RESETN,
  input  logic                     start,
  input  logic [BITS-1:0]          din,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(BITS):0]    count
);

  localparam int N  = BITS / CHUNK;
  localparam int CW = $clog2(BITS) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (((BITS % CHUNK) != 0) || (CHUNK > BITS)) begin : g_bad_cfg
      $error("popcount_seq: BITS must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r;
  logic [BITS-1:0] sh_r;
  logic [CW-1:0]   acc_r;
  logic [IW-1:0]   idx_r;
  logic [CW-1:0]   count_r;
  logic            ready_r;
  logic            busy_r;
  logic            done_r;

  logic [BITS-1:0] sh_next_s;
  logic [CW-1:0]   acc_next_s;
  logic            last_s;

  // Number of ones in one chunk, widened to the accumulator width.
  function automatic logic [CW-1:0] ones(input logic [CHUNK-1:0] v);
    logic [CW-1:0] res;
    res = '0;
    for (int i = 0; i < CHUNK; i++) begin
      res = res + CW'(v[i]);
    end
    return res;
  endfunction

  // Next-cycle datapath values and the end-of-count decision.
  always_comb begin
    sh_next_s  = sh_r >> CHUNK;
    acc_next_s = acc_r + ones(sh_r[CHUNK-1:0]);
`ifdef POPCOUNT_ZERO_SKIP_EN
    if ((idx_r == IW'(N - 1)) || (sh_next_s == '0)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
`else
    if (idx_r == IW'(N - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
`endif
  end

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r <= IDLE;
      sh_r    <= '0;
      acc_r   <= '0;
      idx_r   <= '0;
      count_r <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            sh_r    <= din;
            acc_r   <= '0;
            idx_r   <= '0;
            state_r <= COUNT;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        COUNT: begin
          sh_r  <= sh_next_s;
          acc_r <= acc_next_s;
          idx_r <= idx_r + IW'(1);
          if (last_s) begin
            state_r <= DONE;
            count_r <= acc_next_s;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign count = count_r;

endmodule

// File: doc/popcount_seq.md
POPCOUNT_SEQ -- requirements
Module: popcount_seq

Interface
REQ-001 SHALL have parameter BITS, default 64: width of the input word to be counted.
REQ-002 SHALL have parameter CHUNK, default 8: bits counted per cycle by the shared ones-counter datapath.
REQ-003 SHALL have port clk, input, 1: single clock; all state rising-edge triggered.
REQ-004 SHALL have port CPU_RESETN, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request to count din; sampled only when ready=1.
REQ-006 SHALL have port din, input, BITS: word to count; sampled on the same edge as an accepted start.
REQ-007 SHALL have port ready, output, 1: high only in IDLE.
REQ-008 SHALL have port busy, output, 1: high in COUNT and DONE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, high only in DONE.
REQ-010 SHALL have port count, output, $clog2(BITS)+1: result of the last completed operation.

Function
REQ-011 SHALL implement states IDLE, COUNT and DONE, with N = BITS/CHUNK.
REQ-012 SHALL, in IDLE with start=1, load din into shift register sh, clear accumulator acc and chunk index idx, and go to COUNT.
REQ-013 SHALL, in IDLE with start=0, stay in IDLE with all registers held.
REQ-014 SHALL, per COUNT cycle, set acc += number of ones in sh[CHUNK-1:0], shift sh right by CHUNK (zero fill) and increment idx.
REQ-015 SHALL use an acc width of $clog2(BITS)+1 so the all-ones case (value BITS) does not overflow.
REQ-016 SHALL go from COUNT to DONE after the cycle where idx = N-1; otherwise it stays in COUNT.
REQ-017 SHALL, on entry to DONE, load count with the final acc (this cycle's chunk included).
REQ-018 SHALL hold count until the next entry to DONE.
REQ-019 SHALL return from DONE to IDLE after exactly one cycle, with done=1 during that cycle.
REQ-020 SHALL ignore start while in COUNT or DONE: no queuing, no effect on the current operation.
REQ-021 SHALL, without the macro of REQ-027, have latency from the accepted-start edge to done high of exactly N+1 cycles.
REQ-022 SHALL allow start to be re-accepted on the first cycle back in IDLE, so throughput is one operation per N+2 cycles.
REQ-023 SHALL reject configurations where BITS is not a multiple of CHUNK, or CHUNK > BITS, with an elaboration-time error.

Reset
REQ-024 SHALL, when CPU_RESETN is low, immediately force state=IDLE, sh=0, acc=0, idx=0 and count=0.
REQ-025 SHALL produce, during and after reset, ready=1, busy=0 and done=0.
REQ-026 SHALL, on reset mid-COUNT or mid-DONE, abort the operation, suppress any done pulse for it, and return count to 0.

Configuration
REQ-027 SHALL support macro POPCOUNT_ZERO_SKIP_EN.
REQ-028 SHALL, with POPCOUNT_ZERO_SKIP_EN defined, also exit COUNT to DONE when the shifted sh (after this cycle) is all zero; at least one COUNT cycle always occurs, and the count value is identical to the non-skip result.
REQ-029 SHALL, with POPCOUNT_ZERO_SKIP_EN undefined, use fixed N-cycle COUNT and omit the zero-detect logic.

Verification (BITS=64, CHUNK=8)
REQ-030 SHALL cover: din=64'hFFFF_FFFF_FFFF_FFFF, start pulse -> done 9 cycles later, count=64 (both macro settings).
REQ-031 SHALL cover: din=0 -> count=0; done after 9 cycles without macro, after 2 cycles with POPCOUNT_ZERO_SKIP_EN.
REQ-032 SHALL cover: din=64'h8000_0000_0000_0001 -> count=2, done after 9 cycles in both settings (top chunk non-zero).
REQ-033 SHALL cover: din=64'h0000_0000_0000_00F0 -> count=4; with macro done after 2 cycles.
REQ-034 SHALL cover: start held high continuously with din=64'h0F0F_0F0F_0F0F_0F0F -> operations repeat every 10 cycles, count=32, no start accepted while busy=1.
REQ-035 SHALL cover: CPU_RESETN low during the 4th COUNT cycle -> no done pulse, count=0, ready=1; a new start then yields a correct result.
